// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: two requesters, A and B, share one bank of WIDTH JK flops.
// Round-robin arbitration picks one requester in IDLE. Every access then runs
// a fixed IDLE -> EXEC -> DONE sequence. The latched command is decoded into
// per-bit j/k drives during EXEC, so the bank updates on the EXEC -> DONE edge.
module jk_bank_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [2:0]       op_a,
  input  logic [WIDTH-1:0] mask_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [2:0]       op_b,
  input  logic [WIDTH-1:0] mask_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic             err,
  output logic             busy,
  output logic [WIDTH-1:0] q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_CLEAR  = 3'd1;
  localparam logic [2:0] OP_SET    = 3'd2;
  localparam logic [2:0] OP_TOGGLE = 3'd3;
  localparam logic [2:0] OP_LOAD   = 3'd4;

  // owner / last_served encoding: 0 = A, 1 = B
  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic             winner;
  logic [WIDTH-1:0] j_vec, k_vec;
  logic             illegal;

  // Arbitration. A sole requester wins. On a tie, the side not served last wins.
  always_comb begin
    winner = 1'b0;
    if (req_a && req_b) begin
      winner = ~last_q;
    end else if (req_b) begin
      winner = 1'b1;
    end
  end

  // Next-state logic. The winner's command is captured only on leaving IDLE.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    op_d    = op_q;
    mask_d  = mask_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          state_d = EXEC;
          owner_d = winner;
          last_d  = winner;
          if (winner) begin
            op_d   = op_b;
            mask_d = mask_b;
            data_d = data_b;
          end else begin
            op_d   = op_a;
            mask_d = mask_a;
            data_d = data_a;
          end
        end
      end
      EXEC:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and command registers. Reset makes B the last served, so A wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= '0;
      mask_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      op_q    <= op_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
    end
  end

  assign illegal = (op_q > OP_LOAD);

  // j/k decode. It is active only in EXEC, so the bank holds in every other state.
  always_comb begin
    j_vec = '0;
    k_vec = '0;
    if (state_q == EXEC) begin
      case (op_q)
        OP_NOP:    begin j_vec = '0;      k_vec = '0;      end
        OP_CLEAR:  begin j_vec = '0;      k_vec = mask_q;  end
        OP_SET:    begin j_vec = mask_q;  k_vec = '0;      end
        OP_TOGGLE: begin j_vec = mask_q;  k_vec = mask_q;  end
        OP_LOAD:   begin j_vec = mask_q & data_q; k_vec = mask_q & ~data_q; end
        default:   begin j_vec = '0;      k_vec = '0;      end
      endcase
    end
  end

  // The JK bank: one flop per bit, each cleared asynchronously by reset.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_jk
      logic bit_q;
      // JK flop: 00 hold, 01 clear, 10 set, 11 toggle
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bit_q <= 1'b0;
        end else begin
          case ({j_vec[gi], k_vec[gi]})
            2'b01:   bit_q <= 1'b0;
            2'b10:   bit_q <= 1'b1;
            2'b11:   bit_q <= ~bit_q;
            default: bit_q <= bit_q;
          endcase
        end
      end
      assign q[gi] = bit_q;
    end
  endgenerate

  // All handshake outputs are decoded from registered state only.
  assign gnt_a  = (state_q == EXEC) && !owner_q;
  assign gnt_b  = (state_q == EXEC) &&  owner_q;
  assign done_a = (state_q == DONE) && !owner_q;
  assign done_b = (state_q == DONE) &&  owner_q;
  assign err    = (state_q == DONE) && illegal;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed bench for jk_bank_arbiter (WIDTH=8) with hand-computed expected values.
module tb_jk_bank_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_a, req_b;
  logic [2:0] op_a, op_b;
  logic [7:0] mask_a, mask_b, data_a, data_b;
  logic       gnt_a, gnt_b, done_a, done_b, err, busy;
  logic [7:0] q;

  int n_checks = 0;
  int n_pass   = 0;

  jk_bank_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .op_a(op_a), .mask_a(mask_a), .data_a(data_a),
    .req_b(req_b), .op_b(op_b), .mask_b(mask_b), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
    .err(err), .busy(busy), .q(q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Runs one transaction for A (who_b=0) or B (who_b=1).
  // It is called #1 after a posedge while the FSM is in IDLE.
  task automatic txn(input string tag, input logic who_b, input logic [2:0] op,
                     input logic [7:0] mask, input logic [7:0] data,
                     input logic [7:0] exp_q, input logic exp_err);
    if (who_b) begin req_b = 1'b1; op_b = op; mask_b = mask; data_b = data; end
    else       begin req_a = 1'b1; op_a = op; mask_a = mask; data_a = data; end
    @(posedge clk); #1;
    chk({tag, " gnt_a"}, 32'(gnt_a), 32'(!who_b));
    chk({tag, " gnt_b"}, 32'(gnt_b), 32'(who_b));
    chk({tag, " busy exec"}, 32'(busy), 32'd1);
    chk({tag, " err exec"}, 32'(err), 32'd0);
    chk({tag, " done exec"}, 32'(done_a | done_b), 32'd0);
    @(posedge clk); #1;
    chk({tag, " done_a"}, 32'(done_a), 32'(!who_b));
    chk({tag, " done_b"}, 32'(done_b), 32'(who_b));
    chk({tag, " err"}, 32'(err), 32'(exp_err));
    chk({tag, " q"}, 32'(q), 32'(exp_q));
    req_a = 1'b0; req_b = 1'b0;
    @(posedge clk); #1;
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " idle done"}, 32'(done_a | done_b | err), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = 0; req_b = 0; op_a = 0; op_b = 0;
    mask_a = 0; mask_b = 0; data_a = 0; data_b = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset q", 32'(q), 32'h00);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset outs", 32'({gnt_a, gnt_b, done_a, done_b, err}), 32'd0);

    // Load a nonzero value, then reset in the middle of EXEC of a SET.
    txn("pre set", 1'b0, 3'd2, 8'h3C, 8'h00, 8'h3C, 1'b0);
    req_a = 1'b1; op_a = 3'd2; mask_a = 8'hFF;
    @(posedge clk); #1;
    chk("rst exec gnt_a", 32'(gnt_a), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst async q", 32'(q), 32'h00);
    chk("rst async outs", 32'({gnt_a, gnt_b, done_a, done_b, err, busy}), 32'd0);
    req_a = 1'b0;
    @(posedge clk); #1;
    chk("rst no done", 32'(done_a | done_b), 32'd0);
    rst_n = 1'b1;

    // First tie after reset: A wins, then B is served.
    req_a = 1'b1; op_a = 3'd2; mask_a = 8'h0F;
    req_b = 1'b1; op_b = 3'd0; mask_b = 8'hFF;
    @(posedge clk); #1;
    chk("tie gnt_a", 32'(gnt_a), 32'd1);
    chk("tie gnt_b", 32'(gnt_b), 32'd0);
    @(posedge clk); #1;
    chk("tie done_a", 32'(done_a), 32'd1);
    chk("tie set q", 32'(q), 32'h0F);
    req_a = 1'b0;
    @(posedge clk); #1;
    chk("tie idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("tie then gnt_b", 32'(gnt_b), 32'd1);
    @(posedge clk); #1;
    chk("tie done_b", 32'(done_b), 32'd1);
    chk("nop q", 32'(q), 32'h0F);
    req_b = 1'b0;
    @(posedge clk); #1;

    txn("toggle", 1'b0, 3'd3, 8'hFF, 8'h00, 8'hF0, 1'b0);
    txn("clear",  1'b0, 3'd1, 8'h30, 8'h00, 8'hC0, 1'b0);
    txn("load",   1'b1, 3'd4, 8'h0F, 8'hA5, 8'hC5, 1'b0);

    // Contention: B was served last, so grants must go A,B,A,B.
    req_a = 1'b1; op_a = 3'd0; mask_a = 8'hFF;
    req_b = 1'b1; op_b = 3'd0; mask_b = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rr%0d gnt_a", i), 32'(gnt_a), 32'(i % 2 == 0));
      chk($sformatf("rr%0d gnt_b", i), 32'(gnt_b), 32'(i % 2 == 1));
      @(posedge clk); #1;
      chk($sformatf("rr%0d done_a", i), 32'(done_a), 32'(i % 2 == 0));
      chk($sformatf("rr%0d done_b", i), 32'(done_b), 32'(i % 2 == 1));
      if (i == 3) begin req_a = 1'b0; req_b = 1'b0; end
      @(posedge clk); #1;
      chk($sformatf("rr%0d idle", i), 32'(busy), 32'd0);
    end
    chk("rr q", 32'(q), 32'hC5);

    txn("illegal", 1'b0, 3'd6, 8'hFF, 8'h00, 8'hC5, 1'b1);

    // Stability: only the values sampled at the IDLE->EXEC edge may matter.
    req_a = 1'b1; op_a = 3'd3; mask_a = 8'h0F;
    @(posedge clk); #1;
    op_a = 3'd2; mask_a = 8'hFF;
    @(posedge clk); #1;
    chk("stable done_a", 32'(done_a), 32'd1);
    chk("stable q", 32'(q), 32'hCA);
    req_a = 1'b0;
    @(posedge clk); #1;
    chk("stable idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
